// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
package obi_arb_pkg;

    localparam int ARB_ADDRW = 32;
    localparam int ARB_DATAW = 32;
    localparam int ARB_STRBW = ARB_DATAW / 8;
    localparam int MAX_REQ   = 32;

    typedef struct packed {
        logic [ARB_ADDRW-1:0] addr;
        logic                 we;
        logic [ARB_DATAW-1:0] wdata;
        logic [ARB_STRBW-1:0] be;
    } obi_req_info_t;

    // First asserted request at or after prio, wrapping at num; returns prio if none.
    function automatic int unsigned rr_next(input int unsigned prio,
                                            input logic [MAX_REQ-1:0] req,
                                            input int unsigned num);
        int unsigned idx;
        rr_next = prio;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = (prio + unsigned'(k)) % num;
            if ((unsigned'(k) < num) && (((req >> idx) & MAX_REQ'(1)) != '0)) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted requester indices; head is the owner of the next response.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o  = (cnt_q == CNTW'(DEPTH));
        empty_o = (cnt_q == '0);
        data_o  = mem_q[rptr_q];
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d   = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter with grant locking and in-order response routing
// for NUM_REQ requesters sharing one manager port.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int OBI_ADDRW       = 32,
    parameter int OBI_DATAW       = 32,
    parameter int OBI_STRBW       = OBI_DATAW / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]   wdata_i,
    input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]   be_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [NUM_REQ-1:0][OBI_DATAW-1:0]   rdata_o,
    output logic                                m_req_o,
    output logic [OBI_ADDRW-1:0]                m_addr_o,
    output logic                                m_we_o,
    output logic [OBI_DATAW-1:0]                m_wdata_o,
    output logic [OBI_STRBW-1:0]                m_be_o,
    input  logic                                m_gnt_i,
    input  logic                                m_rvalid_i,
    input  logic [OBI_DATAW-1:0]                m_rdata_i,
    output logic                                err_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    logic [IDXW-1:0] prio_q, prio_d;
    logic [IDXW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic [IDXW-1:0] sel, head;
    logic            full, empty, hs, pop;

    // A pending address phase keeps its slot until granted, so no newcomer can pre-empt it.
    always_comb begin
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            sel = IDXW'(rr_next(32'(prio_q), MAX_REQ'(req_i), NUM_REQ));
        end
    end

    always_comb begin
        m_req_o   = req_i[sel] & ~full & ~rst_i;
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_wdata_o = '0;
        m_be_o    = '0;
        if (m_req_o) begin
            m_addr_o  = addr_i[sel];
            m_we_o    = we_i[sel];
            m_wdata_o = wdata_i[sel];
            m_be_o    = be_i[sel];
        end
        hs    = m_req_o & m_gnt_i;
        gnt_o = '0;
        if (hs) begin
            gnt_o[sel] = 1'b1;
        end
        pop      = m_rvalid_i & ~empty;
        rvalid_o = '0;
        if (pop & ~rst_i) begin
            rvalid_o[head] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rdata_o[i] = rst_i ? '0 : m_rdata_i;
        end
        err_o = err_q & ~rst_i;
    end

    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (m_rvalid_i & empty);
        if (hs) begin
            prio_d = (sel == IDXW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            lock_d = 1'b0;
        end else if (m_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    obi_arb_id_fifo #(
        .WIDTH (IDXW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_obi_rr_arbiter;

    localparam int NR = 2;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, we, gnt_o, rvalid_o;
    logic [1:0][31:0] addr, wdata, rdata_o;
    logic [1:0][3:0]  be;
    logic             m_req_o, m_we_o, m_gnt, m_rvalid, err_o;
    logic [31:0]      m_addr_o, m_wdata_o, m_rdata;
    logic [3:0]       m_be_o;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int  mPrio, mLockIdx;
    bit  mLock, mErr;
    int  mFifo[$];
    int  eSel;
    bit  eReq, eWe, eErr;
    logic [1:0]       eGnt, eRvalid;
    logic [31:0]      eAddr, eWdata;
    logic [3:0]       eBe;
    logic [1:0][31:0] eRdata;

    always #5 clk = ~clk;

    obi_rr_arbiter #(
        .NUM_REQ(NR), .OBI_ADDRW(32), .OBI_DATAW(32), .OBI_STRBW(4), .MAX_OUTSTANDING(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_gnt_i(m_gnt),
        .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .err_o(err_o)
    );

    // Predicts combinational outputs from the current inputs and model state.
    task automatic modelPredict();
        bit found = 0;
        eSel = mPrio;
        if (mLock) begin
            eSel = mLockIdx;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (!found && req[(mPrio + k) % NR]) begin
                    eSel = (mPrio + k) % NR;
                    found = 1;
                end
            end
        end
        eReq = req[eSel] && (mFifo.size() < DEPTH) && !rst;
        eGnt = 2'b00;
        if (eReq && m_gnt) eGnt[eSel] = 1'b1;
        eRvalid = 2'b00;
        if (m_rvalid && mFifo.size() > 0 && !rst) eRvalid[mFifo[0]] = 1'b1;
        eAddr  = eReq ? addr[eSel] : 32'h0;
        eWe    = eReq ? we[eSel] : 1'b0;
        eWdata = eReq ? wdata[eSel] : 32'h0;
        eBe    = eReq ? be[eSel] : 4'h0;
        eRdata = rst ? 64'h0 : {m_rdata, m_rdata};
        eErr   = mErr && !rst;
    endtask

    task automatic modelUpdate();
        if (rst) begin
            mPrio = 0; mLock = 0; mLockIdx = 0; mErr = 0;
            mFifo.delete();
        end else begin
            if (m_rvalid) begin
                if (mFifo.size() > 0) void'(mFifo.pop_front());
                else mErr = 1;
            end
            if (eReq && m_gnt) begin
                mFifo.push_back(eSel);
                mPrio = (eSel + 1) % NR;
                mLock = 0;
            end else if (eReq) begin
                mLock = 1;
                mLockIdx = eSel;
            end
        end
    endtask

    task automatic applyReset();
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        mPrio = 0; mLock = 0; mLockIdx = 0; mErr = 0;
        mFifo.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; addr = {32'h1234, 32'h5678}; m_gnt = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE;
        #1;
        checks++; if (m_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mreq: got %b want 0", m_req_o); end
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL rst_gnt: got %b want 00", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("[TB] FAIL rst_rvalid: got %b want 00", rvalid_o); end
        checks++; if (rdata_o !== 64'h0) begin failures++; $display("[TB] FAIL rst_rdata: got %h want 0", rdata_o); end
        checks++; if (m_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_addr: got %h want 0", m_addr_o); end
        @(negedge clk);
        rst = 1'b0; req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b0;
        #1;
        checks++; if (m_req_o !== 1'b0 || m_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL idle_mreq: got %b/%h want 0/0", m_req_o, m_addr_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b want 0", err_o); end
        @(negedge clk);
    endtask

    task automatic test_alternating();
        logic [1:0] expG, prevG;
        applyReset();
        req = 2'b11; addr = {32'hAB, 32'hAB}; we = 2'b00; m_gnt = 1'b1; m_rdata = 32'h45;
        prevG = 2'b00;
        for (int i = 0; i < 5; i++) begin
            m_rvalid = (i > 0);
            expG = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (gnt_o !== expG) begin failures++; $display("[TB] FAIL alt_gnt[%0d]: got %b want %b", i, gnt_o, expG); end
            checks++; if (rvalid_o !== prevG) begin failures++; $display("[TB] FAIL alt_rvalid[%0d]: got %b want %b", i, rvalid_o, prevG); end
            if (i > 0) begin
                checks++; if (rdata_o[prevG[1]] !== 32'h45) begin failures++; $display("[TB] FAIL alt_rdata[%0d]: got %h want 45", i, rdata_o[prevG[1]]); end
            end
            prevG = expG;
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        applyReset();
        addr = {32'h1111_0000, 32'h0000_0AAA}; req = 2'b10; m_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h1111_0000) begin failures++; $display("[TB] FAIL lock_hold[%0d]: got %b/%h want 1/11110000", i, m_req_o, m_addr_o); end
            @(negedge clk);
        end
        req = 2'b11;
        #1;
        checks++; if (m_addr_o !== 32'h1111_0000 || gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL lock_newcomer: got %h/%b want 11110000/00", m_addr_o, gnt_o); end
        @(negedge clk);
        m_gnt = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("[TB] FAIL lock_first_gnt: got %b want 10", gnt_o); end
        @(negedge clk);
        req = 2'b01;
        #1;
        checks++; if (gnt_o !== 2'b01 || m_addr_o !== 32'h0000_0AAA) begin failures++; $display("[TB] FAIL lock_second_gnt: got %b/%h want 01/00000aaa", gnt_o, m_addr_o); end
        @(negedge clk);
    endtask

    task automatic test_full();
        applyReset();
        req = 2'b01; addr[0] = 32'h100; m_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (gnt_o !== 2'b01) begin failures++; $display("[TB] FAIL full_fill[%0d]: got %b want 01", i, gnt_o); end
            @(negedge clk);
        end
        #1;
        checks++; if (m_req_o !== 1'b0 || gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL full_block: got %b/%b want 0/00", m_req_o, gnt_o); end
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        checks++; if (m_req_o !== 1'b0 || rvalid_o !== 2'b01) begin failures++; $display("[TB] FAIL full_no_bypass: got %b/%b want 0/01", m_req_o, rvalid_o); end
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        checks++; if (m_req_o !== 1'b1 || gnt_o !== 2'b01) begin failures++; $display("[TB] FAIL full_resume: got %b/%b want 1/01", m_req_o, gnt_o); end
        @(negedge clk);
    endtask

    task automatic test_write_routing();
        applyReset();
        req = 2'b11; we = 2'b11; addr = {32'h300, 32'h200};
        wdata = {32'h78, 32'h69}; be = {4'h3, 4'hF}; m_gnt = 1'b0;
        #1;
        checks++; if (m_we_o !== 1'b1 || m_wdata_o !== 32'h69 || m_be_o !== 4'hF) begin failures++; $display("[TB] FAIL wr_port0: got %b/%h/%h want 1/69/f", m_we_o, m_wdata_o, m_be_o); end
        @(negedge clk);
        m_gnt = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("[TB] FAIL wr_gnt0: got %b want 01", gnt_o); end
        @(negedge clk);
        req = 2'b10;
        #1;
        checks++; if (gnt_o !== 2'b10 || m_wdata_o !== 32'h78 || m_be_o !== 4'h3 || m_addr_o !== 32'h300) begin failures++; $display("[TB] FAIL wr_port1: got %b/%h/%h/%h want 10/78/3/300", gnt_o, m_wdata_o, m_be_o, m_addr_o); end
        @(negedge clk);
        req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1;
        #1;
        checks++; if (rvalid_o !== 2'b01 || m_req_o !== 1'b0 || m_wdata_o !== 32'h0) begin failures++; $display("[TB] FAIL wr_resp0: got %b/%b/%h want 01/0/0", rvalid_o, m_req_o, m_wdata_o); end
        @(negedge clk);
        #1;
        checks++; if (rvalid_o !== 2'b10) begin failures++; $display("[TB] FAIL wr_resp1: got %b want 10", rvalid_o); end
        @(negedge clk);
        m_rvalid = 1'b0;
    endtask

    task automatic test_unexpected();
        applyReset();
        m_rvalid = 1'b1; m_rdata = 32'hDEAD;
        #1;
        checks++; if (rvalid_o !== 2'b00 || err_o !== 1'b0) begin failures++; $display("[TB] FAIL unexp_same: got %b/%b want 00/0", rvalid_o, err_o); end
        @(negedge clk);
        m_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (err_o !== 1'b1) begin failures++; $display("[TB] FAIL unexp_sticky[%0d]: got %b want 1", i, err_o); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL unexp_rst: got %b want 0", err_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL unexp_cleared: got %b want 0", err_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        applyReset();
        addr = {32'hB1, 32'hA0}; req = 2'b10; m_gnt = 1'b1;
        @(negedge clk);
        req = 2'b01;
        @(negedge clk);
        rst = 1'b1; req = 2'b11; m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        checks++; if (m_req_o !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 || rdata_o !== 64'h0) begin failures++; $display("[TB] FAIL mid_rst_outs: got %b/%b/%b/%h want all 0", m_req_o, gnt_o, rvalid_o, rdata_o); end
        @(negedge clk);
        rst = 1'b0; m_gnt = 1'b0;
        #1;
        checks++; if (m_addr_o !== 32'hA0 || rvalid_o !== 2'b00) begin failures++; $display("[TB] FAIL mid_after: got %h/%b want a0/00", m_addr_o, rvalid_o); end
        @(negedge clk);
        m_rvalid = 1'b0; m_gnt = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b01 || err_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_gnt_err: got %b/%b want 01/1", gnt_o, err_o); end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit pend [2];
        applyReset();
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    addr[i] = $urandom; we[i] = 1'($urandom_range(0, 1));
                    wdata[i] = $urandom; be[i] = 4'($urandom_range(0, 15));
                end
                req[i] = pend[i];
            end
            m_gnt = ($urandom_range(0, 3) != 0);
            m_rvalid = (mFifo.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 79) == 0);
            m_rdata = $urandom;
            rst = ($urandom_range(0, 149) == 0);
            #1;
            modelPredict();
            checks++; if (m_req_o !== eReq) begin failures++; $display("[TB] FAIL rnd_mreq c%0d: got %b want %b", c, m_req_o, eReq); end
            checks++; if (gnt_o !== eGnt) begin failures++; $display("[TB] FAIL rnd_gnt c%0d: got %b want %b", c, gnt_o, eGnt); end
            checks++; if (rvalid_o !== eRvalid) begin failures++; $display("[TB] FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid_o, eRvalid); end
            checks++; if (m_addr_o !== eAddr || m_we_o !== eWe) begin failures++; $display("[TB] FAIL rnd_addr c%0d: got %h/%b want %h/%b", c, m_addr_o, m_we_o, eAddr, eWe); end
            checks++; if (m_wdata_o !== eWdata || m_be_o !== eBe) begin failures++; $display("[TB] FAIL rnd_wdata c%0d: got %h/%h want %h/%h", c, m_wdata_o, m_be_o, eWdata, eBe); end
            checks++; if (rdata_o !== eRdata) begin failures++; $display("[TB] FAIL rnd_rdata c%0d: got %h want %h", c, rdata_o, eRdata); end
            checks++; if (err_o !== eErr) begin failures++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, err_o, eErr); end
            modelUpdate();
            for (int i = 0; i < NR; i++) begin
                if (eGnt[i] || rst) pend[i] = 0;
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        test_reset();
        test_alternating();
        test_lock();
        test_full();
        test_write_routing();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
